// File: rtl/conbus_rr.sv
// Shared-bus WISHBONE interconnect: NM masters, NS slaves, round-robin grant held
// for the whole cycle, mask/match decode, error on unmapped access or ack timeout.
module conbus_rr #(
    parameter int              NM      = 5,
    parameter int              NS      = 6,
    parameter logic [NS*32-1:0] S_MATCH = {NS{32'h0}},
    parameter logic [NS*32-1:0] S_MASK  = {NS{32'hE000_0000}},
    parameter int              TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NM*32-1:0]  m_dat_i,
    input  logic [NM*32-1:0]  m_adr_i,
    input  logic [NM*3-1:0]   m_cti_i,
    input  logic [NM*4-1:0]   m_sel_i,
    input  logic [NM-1:0]     m_we_i,
    input  logic [NM-1:0]     m_cyc_i,
    input  logic [NM-1:0]     m_stb_i,
    output logic [31:0]       m_dat_o,
    output logic [NM-1:0]     m_ack_o,
    output logic [NM-1:0]     m_err_o,
    output logic [31:0]       s_adr_o,
    output logic [31:0]       s_dat_o,
    output logic [2:0]        s_cti_o,
    output logic [3:0]        s_sel_o,
    output logic              s_we_o,
    output logic              s_stb_o,
    output logic [NS-1:0]     s_cyc_o,
    input  logic [NS*32-1:0]  s_dat_i,
    input  logic [NS-1:0]     s_ack_i,
    output logic [2:0]        gnt_o
);

    logic [2:0]    gnt;
    logic [2:0]    gnt_nxt;
    logic          cyc_g;
    logic [NS-1:0] sel;
    logic [NS-1:0] sel_r;
    logic          ack;
    logic          err_r;
    logic          err_nxt;
    logic [7:0]    cnt;
    logic [8:0]    cnt_inc;
    logic          req_wait;
    logic          unmapped;
    logic          tmo;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_cti_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        cyc_g   = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (gnt == 3'(i)) begin
                s_adr_o = m_adr_i[i*32 +: 32];
                s_dat_o = m_dat_i[i*32 +: 32];
                s_cti_o = m_cti_i[i*3 +: 3];
                s_sel_o = m_sel_i[i*4 +: 4];
                s_we_o  = m_we_i[i];
                s_stb_o = m_stb_i[i];
                cyc_g   = m_cyc_i[i];
            end
        end
    end

    // Rotating search starting after the holder; the holder itself is checked last.
    always_comb begin
        logic found;
        int   idx;
        gnt_nxt = gnt;
        found   = 1'b0;
        idx     = 0;
        if (!cyc_g) begin
            for (int k = 1; k <= NM; k++) begin
                idx = (int'(gnt) + k) % NM;
                for (int j = 0; j < NM; j++) begin
                    if (!found && j == idx && m_cyc_i[j]) begin
                        gnt_nxt = 3'(j);
                        found   = 1'b1;
                    end
                end
            end
        end
    end

    // Lowest-index slave wins when decode windows overlap.
    always_comb begin
        logic hit_any;
        sel     = '0;
        hit_any = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!hit_any &&
                ((s_adr_o & S_MASK[i*32 +: 32]) == (S_MATCH[i*32 +: 32] & S_MASK[i*32 +: 32]))) begin
                sel[i]  = 1'b1;
                hit_any = 1'b1;
            end
        end
    end

    assign s_cyc_o = sel & {NS{cyc_g}};
    assign ack     = |(s_ack_i & sel);
    assign gnt_o   = gnt;

    always_comb begin
        m_dat_o = '0;
        for (int i = 0; i < NS; i++) begin
            if (sel_r[i]) m_dat_o = m_dat_o | s_dat_i[i*32 +: 32];
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        for (int i = 0; i < NM; i++) begin
            m_ack_o[i] = (gnt == 3'(i)) && ack;
            m_err_o[i] = (gnt == 3'(i)) && err_r;
        end
    end

    assign req_wait = cyc_g && s_stb_o && (sel != '0) && !ack;
    assign unmapped = cyc_g && s_stb_o && (sel == '0);
    assign cnt_inc  = {1'b0, cnt} + 9'd1;
    assign tmo      = (TIMEOUT != 0) && req_wait && !err_r && (cnt_inc == 9'(TIMEOUT));
    // Unmapped errors alternate with idle cycles while stb stays high.
    assign err_nxt  = (unmapped && !err_r) || tmo;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gnt   <= '0;
            sel_r <= '0;
            err_r <= 1'b0;
            cnt   <= '0;
        end else begin
            gnt   <= gnt_nxt;
            sel_r <= sel;
            if (gnt_nxt != gnt) begin
                err_r <= 1'b0;
                cnt   <= '0;
            end else begin
                err_r <= err_nxt;
                if (!req_wait || err_r || tmo) cnt <= '0;
                else                           cnt <= cnt_inc[7:0];
            end
        end
    end

endmodule

// File: tb/tb_conbus_rr.sv
// Self-checking bench for conbus_rr: arbitration, decode, read path, error and
// timeout behaviour, and reset during a transfer, against a behavioural model.
module tb_conbus_rr;

    localparam int NM = 5;
    localparam int NS = 6;
    localparam logic [31:0] MATCH_A [NS] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000,
                                             32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    localparam logic [31:0] MASK_A  [NS] = '{32'hE000_0000, 32'hE000_0000, 32'hE000_0000,
                                             32'hC000_0000, 32'hC000_0000, 32'hF000_0000};
    localparam logic [NS*32-1:0] P_MATCH = {MATCH_A[5], MATCH_A[4], MATCH_A[3],
                                            MATCH_A[2], MATCH_A[1], MATCH_A[0]};
    localparam logic [NS*32-1:0] P_MASK  = {MASK_A[5], MASK_A[4], MASK_A[3],
                                            MASK_A[2], MASK_A[1], MASK_A[0]};

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [31:0]       adr_a [NM];
    logic [31:0]       sd    [NS];
    logic [NM*32-1:0]  m_dat_i;
    logic [NM*32-1:0]  m_adr_i;
    logic [NM*3-1:0]   m_cti_i;
    logic [NM*4-1:0]   m_sel_i;
    logic [NM-1:0]     m_we_i;
    logic [NM-1:0]     m_cyc_i;
    logic [NM-1:0]     m_stb_i;
    logic [NS*32-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i;

    logic [31:0]   m_dat_o,  m_dat_o0;
    logic [NM-1:0] m_ack_o,  m_ack_o0;
    logic [NM-1:0] m_err_o,  m_err_o0;
    logic [31:0]   s_adr_o,  s_adr_o0;
    logic [31:0]   s_dat_o,  s_dat_o0;
    logic [2:0]    s_cti_o,  s_cti_o0;
    logic [3:0]    s_sel_o,  s_sel_o0;
    logic          s_we_o,   s_we_o0;
    logic          s_stb_o,  s_stb_o0;
    logic [NS-1:0] s_cyc_o,  s_cyc_o0;
    logic [2:0]    gnt_o,    gnt_o0;

    int n_chk = 0;
    int n_fail = 0;

    assign m_adr_i = {adr_a[4], adr_a[3], adr_a[2], adr_a[1], adr_a[0]};
    assign s_dat_i = {sd[5], sd[4], sd[3], sd[2], sd[1], sd[0]};

    always #5 sys_clk = ~sys_clk;

    conbus_rr #(.NM(NM), .NS(NS), .S_MATCH(P_MATCH), .S_MASK(P_MASK), .TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_cti_i(m_cti_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    conbus_rr #(.NM(NM), .NS(NS), .S_MATCH(P_MATCH), .S_MASK(P_MASK), .TIMEOUT(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_cti_i(m_cti_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o0), .m_ack_o(m_ack_o0), .m_err_o(m_err_o0),
        .s_adr_o(s_adr_o0), .s_dat_o(s_dat_o0), .s_cti_o(s_cti_o0), .s_sel_o(s_sel_o0),
        .s_we_o(s_we_o0), .s_stb_o(s_stb_o0), .s_cyc_o(s_cyc_o0),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // First decode window that contains the address, scanning slave 0 upward.
    function automatic logic [NS-1:0] dec_model(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & MASK_A[3'(i)]) == (MATCH_A[3'(i)] & MASK_A[3'(i)]))
                return NS'(1) << i;
        end
        return '0;
    endfunction

    // Holder keeps the bus while requesting; otherwise the next requester after it wins.
    function automatic logic [2:0] arb_model(input logic [2:0] g, input logic [NM-1:0] req);
        int idx;
        if (req[g]) return g;
        for (int k = 1; k < NM; k++) begin
            idx = (int'(g) + k) % NM;
            if (req[3'(idx)]) return 3'(idx);
        end
        return g;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    gm;
        logic [NM-1:0] req;
        logic [31:0]   rd;
        logic [31:0]   a;

        sys_rst = 1'b1;
        m_dat_i = '0;
        m_cti_i = '0;
        m_sel_i = '1;
        m_we_i  = '0;
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = '0;
        for (int i = 0; i < NM; i++) adr_a[i] = 32'h0000_0010;
        for (int i = 0; i < NS; i++) sd[i] = $urandom | 32'h1;

        // Reset state
        tick();
        tick();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_ack", 32'(m_ack_o), 32'd0);
        chk("rst_err", 32'(m_err_o), 32'd0);
        chk("rst_dat", m_dat_o, 32'd0);
        sys_rst = 1'b0;

        // All masters request at once, each does one acked transfer then drops cyc
        m_cyc_i = '1;
        m_stb_i = '1;
        gm = 3'd0;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk("rr_gnt", 32'(gnt_o), 32'(gm));
            tick();
            rd = $urandom;
            sd[0] = rd;
            s_ack_i = 6'b000001;
            #1;
            chk("rr_ack", 32'(m_ack_o), 32'(NM'(1) << gm));
            chk("rr_dat", m_dat_o, rd);
            tick();
            s_ack_i = '0;
            m_cyc_i[gm] = 1'b0;
            m_stb_i[gm] = 1'b0;
            if (t == 4) begin
                m_cyc_i[0] = 1'b1;
                m_stb_i[0] = 1'b1;
            end
            #1;
            chk("rr_hold", 32'(gnt_o), 32'(gm));
            gm = arb_model(gm, m_cyc_i);
            tick();
        end
        chk("rr_idle_hold", 32'(gnt_o), 32'(gm));

        // Random request patterns against the arbitration model
        for (int r = 0; r < 16; r++) begin
            req = NM'($urandom_range(0, 31));
            m_cyc_i = req;
            #1;
            gm = arb_model(gm, req);
            tick();
            chk("rand_gnt", 32'(gnt_o), 32'(gm));
        end
        m_cyc_i = '0;
        tick();

        // Decode: master 1 reads from slave 4
        m_cyc_i = 5'b00010;
        tick();
        chk("dec_gnt1", 32'(gnt_o), 32'd1);
        adr_a[1] = 32'h8000_0010;
        m_stb_i = 5'b00010;
        #1;
        chk("dec_cyc4", 32'(s_cyc_o), 32'(6'b010000));
        chk("dec_adr", s_adr_o, 32'h8000_0010);
        chk("dec_noack", 32'(m_ack_o), 32'd0);
        tick();
        sd[4] = 32'hDEAD_BEEF;
        s_ack_i = 6'b010001;
        #1;
        chk("dec_dat", m_dat_o, 32'hDEAD_BEEF);
        chk("dec_ack", 32'(m_ack_o), 32'(5'b00010));
        tick();
        s_ack_i = 6'b000001;
        #1;
        chk("dec_stray_ack", 32'(m_ack_o), 32'd0);
        tick();
        s_ack_i = '0;
        adr_a[1] = 32'h4000_0000;
        #1;
        chk("dec_overlap", 32'(s_cyc_o), 32'(6'b000100));
        tick();
        for (int r = 0; r < 10; r++) begin
            a = $urandom;
            adr_a[1] = a;
            #1;
            chk("dec_rand", 32'(s_cyc_o), 32'(dec_model(a)));
            tick();
        end
        m_stb_i = '0;
        tick();

        // Unmapped address, stb held for four cycles
        adr_a[1] = 32'hE000_0000;
        m_stb_i = 5'b00010;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("unm_err", 32'(m_err_o), (j % 2 == 1) ? 32'(5'b00010) : 32'd0);
            chk("unm_cyc", 32'(s_cyc_o), 32'd0);
            tick();
        end
        m_stb_i = '0;
        tick();

        // Mapped slave that never acks: error every 17th cycle, never with TIMEOUT=0
        adr_a[1] = 32'h0000_0100;
        m_stb_i = 5'b00010;
        for (int c = 1; c <= 300; c++) begin
            #1;
            chk("tmo_err", 32'(m_err_o), (c % 17 == 0) ? 32'(5'b00010) : 32'd0);
            chk("tmo0_err", 32'(m_err_o0), 32'd0);
            tick();
        end
        m_stb_i = '0;
        m_cyc_i = '0;
        adr_a[0] = 32'h0000_0000;
        tick();

        // Reset while master 3 is mid-transfer with a stray slave-1 ack
        m_cyc_i = 5'b01000;
        tick();
        chk("mrst_gnt3", 32'(gnt_o), 32'd3);
        adr_a[3] = 32'hE000_0000;
        m_stb_i = 5'b01000;
        s_ack_i = 6'b000010;
        sys_rst = 1'b1;
        #1;
        chk("mrst_pre_ack", 32'(m_ack_o), 32'd0);
        tick();
        chk("mrst_gnt0", 32'(gnt_o), 32'd0);
        chk("mrst_err", 32'(m_err_o), 32'd0);
        chk("mrst_ack", 32'(m_ack_o), 32'd0);
        sys_rst = 1'b0;
        s_ack_i = '0;
        tick();
        chk("mrst_regrant", 32'(gnt_o), 32'd3);
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conbus_rr.md
# conbus_rr

Parametrised WISHBONE shared-bus interconnect: NM masters, NS slaves, one shared transfer path. Round-robin arbitration with grant held for the whole cycle, mask/match address decoding per slave, and an error response for unmapped addresses and for slaves that never acknowledge. It is the system interconnect between the CPU/DMA masters and the memory and CSR-bridge slaves, replacing fixed-count crossbars with one generic block.

## Interface
Parameters:
- NM, 5, master count, 1..8
- NS, 6, slave count, 1..8
- S_MATCH, {NS{32'h0}}, packed NS×32; slave i match value at bits [32i+31:32i]
- S_MASK, {NS{32'hE000_0000}}, packed NS×32; slave i decode mask
- TIMEOUT, 255, cycles without ack before error (8-bit counter); 0 disables timeout

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active high
- m_dat_i  in  NM×32  master write data, packed
- m_adr_i  in  NM×32  master address
- m_cti_i  in  NM×3  cycle type
- m_sel_i  in  NM×4  byte select
- m_we_i, m_cyc_i, m_stb_i  in  NM each  per-master controls
- m_dat_o  out  32  read data, shared by all masters
- m_ack_o  out  NM  ack, only to granted master
- m_err_o  out  NM  error, only to granted master
- s_adr_o, s_dat_o, s_cti_o, s_sel_o, s_we_o, s_stb_o  out  32/32/3/4/1/1  shared slave bus
- s_cyc_o  out  NS  per-slave cyc, decoded
- s_dat_i  in  NS×32  slave read data, packed
- s_ack_i  in  NS  slave acks
- gnt_o  out  3  current grant index

## Operation
- Grant register gnt (3 bits). All shared slave outputs = granted master's signals; non-granted masters see ack/err = 0.
- Arbitration: while m_cyc_i[gnt]=1 grant is held. When m_cyc_i[gnt]=0, the next gnt is the first requesting master in order gnt+1, gnt+2, … wrapping at NM-1→0; the current master is considered last. If no master requests, gnt holds.
- Decode: hit[i] = ((s_adr_o & S_MASK[i]) == (S_MATCH[i] & S_MASK[i])). Lowest index wins on overlap (one-hot sel). s_cyc_o[i] = cyc_granted & sel[i].
- sel_r <= sel every cycle; m_dat_o = OR over i of (sel_r[i] ? s_dat_i[i] : 0). Slaves ack no earlier than the cycle after stb; this is the interconnect's contract.
- m_ack_o[gnt] = |(s_ack_i & sel). Acks of unselected slaves are ignored.
- Unmapped: cyc&stb with sel=0 -> err_r set next cycle for one cycle, then cleared; if stb is still high it re-fires, so err alternates 1/0.
- Timeout: 8-bit counter increments each cycle cyc&stb&sel≠0 and no ack; cleared on ack, err, stb low or grant change. Counter reaching TIMEOUT -> err_r pulse for one cycle, counter cleared. TIMEOUT=0: never fires.
- m_err_o[gnt] = err_r. No ack and err together: err_r is generated only when no ack is presented in the triggering cycle.

## Timing
- Reset: gnt=0, sel_r=0, err_r=0, counter=0. Combinational outputs then follow master 0 (m_dat_o=0, all ack/err=0 if master 0 idle).
- Grant change latency: 1 cycle after the holder drops cyc (drop seen at edge N, new gnt valid from N+1); new master's stb is forwarded in the same cycle gnt updates.
- Reset mid-transfer: gnt forced to 0 and err/counter cleared at the next edge; any in-flight ack is passed through combinationally only if master 0 is the target.
- Simultaneous requests after reset: master 0 holds (gnt already 0); on release, master 1 wins over 2..NM-1.
- Grant update and counter clear happen on the same edge; err_r pending for old master is dropped on grant change.

## Test plan
- NM=5: m0..m4 all assert cyc at once from idle, each drops cyc after one acked transfer -> gnt_o sequence 0,1,2,3,4,0, each change 1 cycle after drop.
- Decode: S_MATCH[4]=32'h8000_0000, mask 32'hC000_0000; m1 reads 32'h8000_0010 -> only s_cyc_o[4]=1; slave 4 returns 32'hDEAD_BEEF with ack next cycle -> m_dat_o=32'hDEAD_BEEF, m_ack_o=5'b00010.
- Overlapping slaves 2 and 3 both hit 32'h4000_0000 -> only s_cyc_o[2] asserted.
- Unmapped address with no slave hit, stb held 4 cycles -> m_err_o[gnt] pattern 0,1,0,1; s_cyc_o all 0.
- TIMEOUT=16, mapped slave never acks -> err one cycle on cycle 17 after stb; counter restarts; with TIMEOUT=0 no err after 300 cycles.
- sys_rst asserted while gnt=3 mid-burst -> next cycle gnt_o=0, m_err_o=0, stray ack from slave 1 not seen by master 3.
